dac_parallel_tx: RTL and testbench



---
 rtl/dac_parallel_tx.sv | 150 +++++++++++++++
 tb/tb_dac_parallel_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_parallel_tx.sv
// rtl/dac_parallel_tx.sv - FIFO-buffered sample stream to a parallel 10-bit DAC with generated latch clock
module dac_parallel_tx #(
    parameter int CLK_FRE   = 50,
    parameter int DAC_FRE   = 5000,
    parameter int PRIME_LVL = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dac_en,
    input  logic [9:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [4:0] fifo_level,
    output logic       underflow,
    output logic [7:0] underrun_cnt,
    output logic [9:0] dac_db,
    output logic       dac_clk
);
    localparam int DIV = (CLK_FRE * 1000) / DAC_FRE;
    localparam int CW  = (DIV < 4) ? 2 : $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX     = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF    = CW'(DIV / 2);
    localparam logic [4:0]    PRIME_LEVEL = 5'(PRIME_LVL);
    localparam logic [9:0]    MID_SCALE   = 10'd512;

    if (DIV < 4 || ((CLK_FRE * 1000) % DAC_FRE) != 0) begin : g_bad_div
        $error("dac_parallel_tx: CLK_FRE*1000/DAC_FRE must be an integer >= 4");
    end
    if (PRIME_LVL < 1 || PRIME_LVL > 16) begin : g_bad_prime
        $error("dac_parallel_tx: PRIME_LVL must be in 1..16");
    end

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    dac_db_q, dac_db_d;
    logic          dac_clk_q, dac_clk_d;
    logic          underflow_q, underflow_d;
    logic [7:0]    underrun_q, underrun_d;
    logic [4:0]    level_q, level_d;
    logic [3:0]    wr_ptr_q, wr_ptr_d;
    logic [3:0]    rd_ptr_q, rd_ptr_d;
    logic [9:0]    mem_q [16];
    logic          push, pop, tick;

    assign s_ready      = (level_q != 5'd16);
    assign fifo_level   = level_q;
    assign underflow    = underflow_q;
    assign underrun_cnt = underrun_q;
    assign dac_db       = dac_db_q;
    assign dac_clk      = dac_clk_q;

    // Next-state: update-rate divider, run FSM, pop/underflow decisions and FIFO bookkeeping
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dac_db_d    = dac_db_q;
        underflow_d = 1'b0;
        underrun_d  = underrun_q;
        pop         = 1'b0;
        push        = s_valid && s_ready;
        tick        = (state_q != IDLE) && (cnt_q == CNT_MAX);

        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                dac_db_d = MID_SCALE;
                if (dac_en) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                cnt_d = tick ? '0 : cnt_q + CW'(1);
                if (tick) begin
                    if (!dac_en) begin
                        state_d  = IDLE;
                        dac_db_d = MID_SCALE;
                    end else if (level_q >= PRIME_LEVEL) begin
                        state_d  = RUN;
                        pop      = 1'b1;
                        dac_db_d = mem_q[rd_ptr_q];
                    end
                end
            end
            RUN: begin
                cnt_d = tick ? '0 : cnt_q + CW'(1);
                if (tick) begin
                    if (!dac_en) begin
                        // Drain tick: finish the period, park mid-scale, keep FIFO contents
                        state_d  = IDLE;
                        dac_db_d = MID_SCALE;
                    end else if (level_q != 5'd0) begin
                        pop      = 1'b1;
                        dac_db_d = mem_q[rd_ptr_q];
                    end else begin
                        underflow_d = 1'b1;
                        if (underrun_q != 8'hFF) begin
                            underrun_d = underrun_q + 8'd1;
                        end
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                dac_db_d = MID_SCALE;
            end
        endcase

        // Latch clock rises half a period after each data change
        dac_clk_d = (state_d != IDLE) && (cnt_d >= CNT_HALF);

        level_d  = level_q + {4'd0, push} - {4'd0, pop};
        wr_ptr_d = push ? wr_ptr_q + 4'd1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 4'd1 : rd_ptr_q;
    end

    // State registers; reset wins over any in-flight push or pop
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dac_db_q    <= MID_SCALE;
            dac_clk_q   <= 1'b0;
            underflow_q <= 1'b0;
            underrun_q  <= 8'd0;
            level_q     <= 5'd0;
            wr_ptr_q    <= 4'd0;
            rd_ptr_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dac_db_q    <= dac_db_d;
            dac_clk_q   <= dac_clk_d;
            underflow_q <= underflow_d;
            underrun_q  <= underrun_d;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Sample storage; no reset needed since occupancy is tracked by level_q
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end
endmodule

// File: tb/tb_dac_parallel_tx.sv
// tb/tb_dac_parallel_tx.sv - directed self-checking bench for dac_parallel_tx
module tb_dac_parallel_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic       dac_en;
    logic [9:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [4:0] fifo_level;
    logic       underflow;
    logic [7:0] underrun_cnt;
    logic [9:0] dac_db;
    logic       dac_clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    dac_parallel_tx #(.CLK_FRE(50), .DAC_FRE(5000), .PRIME_LVL(8)) dut (
        .clk(clk), .rst(rst), .dac_en(dac_en), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .fifo_level(fifo_level), .underflow(underflow),
        .underrun_cnt(underrun_cnt), .dac_db(dac_db), .dac_clk(dac_clk)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; dac_en = 1'b0; s_valid = 1'b0; s_data = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic push_seq(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = 10'(base + i);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (dac_db !== 10'd512) begin failures++; $display("FAIL reset_dac_db got=%0d exp=512", dac_db); end
        checks++; if (dac_clk !== 1'b0) begin failures++; $display("FAIL reset_dac_clk got=%b exp=0", dac_clk); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
        checks++; if (underrun_cnt !== 8'd0) begin failures++; $display("FAIL reset_underrun got=%0d exp=0", underrun_cnt); end
    endtask

    task automatic test_prime_empty();
        int   last_rise, high_len, rises, bad_db, uf;
        logic prev_clk;
        do_reset();
        dac_en = 1'b1;
        last_rise = -1; high_len = 0; rises = 0; bad_db = 0; uf = 0; prev_clk = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (dac_db !== 10'd512) bad_db++;
            if (underflow !== 1'b0) uf++;
            if (dac_clk && !prev_clk) begin
                if (last_rise >= 0) begin
                    checks++; if (t - last_rise != 10) begin failures++; $display("FAIL prime_period got=%0d exp=10", t - last_rise); end
                end
                last_rise = t;
                rises++;
            end
            if (!dac_clk && prev_clk) begin
                checks++; if (high_len != 5) begin failures++; $display("FAIL prime_high got=%0d exp=5", high_len); end
            end
            high_len = dac_clk ? high_len + 1 : 0;
            prev_clk = dac_clk;
        end
        checks++; if (rises != 6) begin failures++; $display("FAIL prime_rises got=%0d exp=6", rises); end
        checks++; if (bad_db != 0) begin failures++; $display("FAIL prime_db_not_mid got=%0d exp=0", bad_db); end
        checks++; if (uf != 0) begin failures++; $display("FAIL prime_underflow got=%0d exp=0", uf); end
        @(posedge clk); #1;
        dac_en = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    task automatic test_run_sequence();
        int         idx, last_chg, uf, last_uf;
        logic       pending, prev_clk, found;
        logic [9:0] prev_db;
        do_reset();
        push_seq(100, 8);
        checks++; if (fifo_level !== 5'd8) begin failures++; $display("FAIL run_level got=%0d exp=8", fifo_level); end
        dac_en = 1'b1;
        idx = 0; last_chg = -1; uf = 0; pending = 1'b0;
        prev_db = dac_db; prev_clk = dac_clk;
        for (int t = 0; t < 88; t++) begin
            @(negedge clk);
            if (underflow) uf++;
            if (dac_db !== prev_db) begin
                checks++; if (dac_db !== 10'(100 + idx)) begin failures++; $display("FAIL run_value got=%0d exp=%0d", dac_db, 100 + idx); end
                if (last_chg >= 0) begin
                    checks++; if (t - last_chg != 10) begin failures++; $display("FAIL run_step got=%0d exp=10", t - last_chg); end
                end
                last_chg = t; pending = 1'b1; idx++;
            end
            if (dac_clk && !prev_clk && pending) begin
                checks++; if (t - last_chg != 5) begin failures++; $display("FAIL run_setup got=%0d exp=5", t - last_chg); end
                pending = 1'b0;
            end
            prev_db = dac_db; prev_clk = dac_clk;
        end
        checks++; if (idx != 8) begin failures++; $display("FAIL run_count got=%0d exp=8", idx); end
        checks++; if (uf != 0) begin failures++; $display("FAIL run_early_underflow got=%0d exp=0", uf); end

        last_uf = -1;
        for (int k = 1; k <= 3; k++) begin
            found = 1'b0;
            for (int w = 0; w < 15 && !found; w++) begin
                @(negedge clk);
                if (underflow === 1'b1) found = 1'b1;
            end
            checks++;
            if (!found) begin
                failures++; $display("FAIL uf_wait got=none exp=pulse%0d", k);
            end else begin
                checks++; if (underrun_cnt !== 8'(k)) begin failures++; $display("FAIL uf_count got=%0d exp=%0d", underrun_cnt, k); end
                checks++; if (dac_db !== 10'd107) begin failures++; $display("FAIL uf_hold got=%0d exp=107", dac_db); end
                if (last_uf >= 0) begin
                    checks++; if (cyc - last_uf != 10) begin failures++; $display("FAIL uf_period got=%0d exp=10", cyc - last_uf); end
                end
                last_uf = cyc;
            end
        end
        repeat (3000) @(posedge clk);
        @(negedge clk);
        checks++; if (underrun_cnt !== 8'd255) begin failures++; $display("FAIL uf_saturate got=%0d exp=255", underrun_cnt); end
        checks++; if (dac_db !== 10'd107) begin failures++; $display("FAIL uf_final_hold got=%0d exp=107", dac_db); end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL uf_level got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_back_to_back();
        int         n_acc, n_out;
        logic       rdy, first;
        logic [9:0] prev_db;
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1;
            s_data  = 10'(200 + n_acc);
            rdy     = s_ready;
            @(posedge clk); #1;
            if (rdy) n_acc++;
        end
        checks++; if (n_acc != 16) begin failures++; $display("FAIL b2b_accepted got=%0d exp=16", n_acc); end
        checks++; if (fifo_level !== 5'd16) begin failures++; $display("FAIL b2b_full_level got=%0d exp=16", fifo_level); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%b exp=0", s_ready); end
        dac_en = 1'b1;
        n_out = 0; first = 1'b1; prev_db = dac_db;
        for (int c = 0; c < 260 && n_out < 20; c++) begin
            if (n_acc < 20) begin
                s_valid = 1'b1;
                s_data  = 10'(200 + n_acc);
            end else begin
                s_valid = 1'b0;
            end
            rdy = s_ready;
            @(negedge clk);
            if (dac_db !== prev_db) begin
                checks++; if (dac_db !== 10'(200 + n_out)) begin failures++; $display("FAIL b2b_order got=%0d exp=%0d", dac_db, 200 + n_out); end
                if (first) begin
                    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_pop got=%b exp=1", s_ready); end
                    first = 1'b0;
                end
                n_out++;
                prev_db = dac_db;
            end
            @(posedge clk); #1;
            if (rdy && s_valid) n_acc++;
        end
        s_valid = 1'b0;
        checks++; if (n_out != 20) begin failures++; $display("FAIL b2b_out_count got=%0d exp=20", n_out); end
        checks++; if (n_acc != 20) begin failures++; $display("FAIL b2b_in_count got=%0d exp=20", n_acc); end
        repeat (12) @(posedge clk);
        @(negedge clk);
        checks++; if (dac_db !== 10'd219) begin failures++; $display("FAIL b2b_last_hold got=%0d exp=219", dac_db); end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL b2b_empty got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_drain_and_reset();
        logic found;
        int   bad_hold, bad_idle;
        do_reset();
        push_seq(300, 10);
        dac_en = 1'b1;
        found = 1'b0;
        for (int w = 0; w < 40 && !found; w++) begin
            @(negedge clk);
            if (dac_db === 10'd301) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("FAIL drain_wait got=%0d exp=301", dac_db); end
        repeat (3) @(posedge clk);
        #1;
        dac_en = 1'b0;
        bad_hold = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (dac_db !== 10'd301) bad_hold++;
        end
        checks++; if (bad_hold != 0) begin failures++; $display("FAIL drain_hold got=%0d exp=0", bad_hold); end
        @(negedge clk);
        checks++; if (dac_db !== 10'd512) begin failures++; $display("FAIL drain_mid got=%0d exp=512", dac_db); end
        checks++; if (fifo_level !== 5'd8) begin failures++; $display("FAIL drain_level got=%0d exp=8", fifo_level); end
        bad_idle = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dac_db !== 10'd512 || dac_clk !== 1'b0 || fifo_level !== 5'd8) bad_idle++;
        end
        checks++; if (bad_idle != 0) begin failures++; $display("FAIL drain_idle got=%0d exp=0", bad_idle); end

        @(posedge clk); #1;
        dac_en = 1'b1;
        found = 1'b0;
        for (int w = 0; w < 40 && !found; w++) begin
            @(negedge clk);
            if (dac_db !== 10'd512) found = 1'b1;
        end
        checks++; if (dac_db !== 10'd302) begin failures++; $display("FAIL drain_resume got=%0d exp=302", dac_db); end

        repeat (95) @(posedge clk);
        @(negedge clk);
        checks++; if (underrun_cnt !== 8'd2) begin failures++; $display("FAIL pre_rst_underrun got=%0d exp=2", underrun_cnt); end
        checks++; if (dac_db !== 10'd309) begin failures++; $display("FAIL pre_rst_db got=%0d exp=309", dac_db); end

        @(posedge clk); #1;
        rst = 1'b1; s_valid = 1'b1; s_data = 10'd5;
        @(posedge clk); #1;
        checks++; if (dac_db !== 10'd512) begin failures++; $display("FAIL rst_dac_db got=%0d exp=512", dac_db); end
        checks++; if (dac_clk !== 1'b0) begin failures++; $display("FAIL rst_dac_clk got=%b exp=0", dac_clk); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_s_ready got=%b exp=1", s_ready); end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL rst_underflow got=%b exp=0", underflow); end
        checks++; if (underrun_cnt !== 8'd0) begin failures++; $display("FAIL rst_underrun got=%0d exp=0", underrun_cnt); end
        rst = 1'b0; s_valid = 1'b0; dac_en = 1'b0;
        @(posedge clk); #1;
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL rst_push_dropped got=%0d exp=0", fifo_level); end
    endtask

    initial begin
        rst = 1'b1; dac_en = 1'b0; s_valid = 1'b0; s_data = '0;
        test_reset();
        test_prime_empty();
        test_run_sequence();
        test_back_to_back();
        test_drain_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
